// File: rtl/fft_load_ctrl.sv
// fft_load_ctrl: moves one frame of N = 2^log2n complex samples from an
// input FIFO into the FFT working RAM, one sample per cycle whenever the
// FIFO has data.
// Optional feature macro: FFT_LOAD_BITREV_EN -- when defined, the write
// address is the sample index bit-reversed over its low log2n bits
// (decimation-in-time input order); otherwise samples land in natural order.
module fft_load_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_log2n,
  input  logic              i_fifo_empty,
  input  logic [31:0]       i_fifo_dout,
  output logic              o_fifo_rd_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  output logic              o_busy,
  output logic              o_load_done,
  output logic              o_cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;            // index of the next sample to read
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;  // N-1 for the current frame
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ram_we_q, ram_we_d;
  logic              cfg_err_q, cfg_err_d;

  logic              rd_en;
  logic              cfg_ok;
  logic [ADDR_W-1:0] start_mask;   // 2^i_log2n - 1, built bit by bit
  logic [ADDR_W-1:0] cnt_mapped;   // RAM address for sample cnt_q

  // A frame length is legal from 8 points up to the full RAM depth.
  assign cfg_ok = (i_log2n >= 4'd3) && (int'(i_log2n) <= ADDR_W);

  // Low i_log2n bits set: the last sample index of the requested frame.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_mask
      assign start_mask[gi] = (gi < int'(i_log2n));
    end
  endgenerate

`ifdef FFT_LOAD_BITREV_EN
  logic [3:0]        shift_q, shift_d;   // ADDR_W - log2n of current frame
  logic [ADDR_W-1:0] cnt_rev;

  // Full-width reversal puts index bits at the top; shifting right by
  // ADDR_W - log2n aligns them to a reversal over the low log2n bits and
  // leaves the upper address bits zero.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_rev
      assign cnt_rev[gi] = cnt_q[ADDR_W-1-gi];
    end
  endgenerate

  assign cnt_mapped = cnt_rev >> shift_q;

  // Shift amount is captured with the frame length and held for the frame.
  always_comb begin
    shift_d = shift_q;
    if (state_q == IDLE && i_start && cfg_ok) begin
      shift_d = 4'(ADDR_W) - i_log2n;
    end
  end

  // Shift amount register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end
`else
  assign cnt_mapped = cnt_q;
`endif

  // Reads happen only while loading and only when the FIFO has data.
  assign rd_en = (state_q == LOAD) && !i_fifo_empty;

  // Next-state, counter and write-pipeline logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    addr_d     = addr_q;
    ram_we_d   = rd_en;
    cfg_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (cfg_ok) begin
            last_idx_d = start_mask;
            cnt_d      = '0;
            state_d    = LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (rd_en) begin
          cnt_d  = cnt_q + ADDR_W'(1);
          addr_d = cnt_mapped;
          if (cnt_q == last_idx_q) begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        // The final sample's write happens here; a start is honoured
        // again from the next cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      addr_q     <= '0;
      ram_we_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      addr_q     <= addr_d;
      ram_we_q   <= ram_we_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign o_ram_we     = ram_we_q;
  assign o_ram_addr   = addr_q;
  // FIFO data arrives the cycle after the read, which is the write cycle;
  // gated so the data bus is quiet when no write is issued.
  assign o_ram_wdata  = ram_we_q ? i_fifo_dout : 32'd0;
  assign o_busy       = (state_q != IDLE);
  assign o_load_done  = (state_q == LAST);
  assign o_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fft_load_ctrl.sv
// Directed testbench for fft_load_ctrl (default ADDR_W = 10). Expected
// addresses follow FFT_LOAD_BITREV_EN when the bench is built with it.
module tb_fft_load_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [3:0]    i_log2n = 4'd0;
  logic          i_fifo_empty = 1'b1;
  logic [31:0]   i_fifo_dout = 32'd0;
  logic          o_fifo_rd_en;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_wdata;
  logic          o_busy;
  logic          o_load_done;
  logic          o_cfg_err;

  always #5 clk = ~clk;

  fft_load_ctrl #(.ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_log2n     (i_log2n),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_dout (i_fifo_dout),
    .o_fifo_rd_en(o_fifo_rd_en),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_wdata (o_ram_wdata),
    .o_busy      (o_busy),
    .o_load_done (o_load_done),
    .o_cfg_err   (o_cfg_err)
  );

  int checks = 0;
  int failures = 0;

  // FIFO model position and per-frame observation log
  int            rd_ptr = 0;
  logic          rd_pending;
  int            rd_total, wr_n, done_n, done_cyc, err_n, viol_n, end_cyc;
  logic          timed_out;
  int            wr_cyc [0:63];
  logic [AW-1:0] wr_addr[0:63];
  logic [31:0]   wr_data[0:63];

  function automatic logic [31:0] word(input int i);
    return {16'(i * 3 + 256), 16'(i ^ 16'h5A00)};
  endfunction

  function automatic int exp_addr(input int k, input int l2n);
`ifdef FFT_LOAD_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < l2n; b++) begin
      if (k[b]) r = r | (1 << (l2n - 1 - b));
    end
    return r;
`else
    return k & ((1 << l2n) - 1);
`endif
  endfunction

  // Drives one start and then cycles the FIFO model until the DUT goes idle
  // (or until stop_wr writes were seen). gap_at/gap_len hold the FIFO empty
  // for gap_len cycles once gap_at words have been read; poke_cyc re-asserts
  // i_start (with log2n=3) in that loop cycle.
  task automatic run_frame(input logic [3:0] l2n, input int gap_at, input int gap_len,
                           input int stop_wr, input int poke_cyc);
    int   gap_cnt;
    int   rd_n;
    logic rd;
    gap_cnt = 0; rd_n = 0;
    wr_n = 0; done_n = 0; done_cyc = -1; err_n = 0; viol_n = 0; end_cyc = -1;
    timed_out = 1'b1; rd_pending = 1'b0;
    i_start = 1'b1; i_log2n = l2n; i_fifo_empty = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      i_start = (cyc == poke_cyc);
      i_log2n = (cyc == poke_cyc) ? 4'd3 : l2n;
      i_fifo_empty = 1'b0;
      if (rd_n == gap_at && gap_cnt < gap_len) begin
        i_fifo_empty = 1'b1;
        gap_cnt++;
      end
      #1;
      rd = o_fifo_rd_en;
      if (rd && i_fifo_empty) viol_n++;
      if (o_ram_we) begin
        if (wr_n < 64) begin
          wr_addr[wr_n] = o_ram_addr;
          wr_data[wr_n] = o_ram_wdata;
          wr_cyc[wr_n]  = cyc;
        end
        wr_n++;
      end
      if (o_load_done) begin done_n++; done_cyc = cyc; end
      if (o_cfg_err) err_n++;
      if ((stop_wr > 0 && wr_n == stop_wr) || !o_busy) begin
        end_cyc = cyc; timed_out = 1'b0; rd_pending = rd;
        break;
      end
      @(posedge clk); #1;
      if (rd) begin
        i_fifo_dout = word(rd_ptr);
        rd_ptr++; rd_n++;
      end
    end
    rd_total = rd_n;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    checks++; if (o_fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", o_fifo_rd_en); end
    checks++; if (o_ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", o_ram_we); end
    checks++; if (o_load_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_load_done); end
    checks++; if (o_cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b want=0", o_cfg_err); end
    checks++; if (o_ram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", o_ram_addr); end
    i_rst = 1'b0;
    $display("test_reset done");
  endtask

  // 8-point frame started in the first cycle after reset release.
  task automatic test_frame8();
    int base;
    base = rd_ptr;
    run_frame(4'd3, -1, 0, 0, -1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL f8_timeout got=%b want=0", timed_out); end
    checks++; if (wr_n != 8) begin failures++; $display("FAIL f8_writes got=%0d want=8", wr_n); end
    checks++; if (rd_total != 8) begin failures++; $display("FAIL f8_reads got=%0d want=8", rd_total); end
    checks++; if (done_n != 1 || done_cyc != 8) begin failures++; $display("FAIL f8_done got=%0d@%0d want=1@8", done_n, done_cyc); end
    checks++; if (end_cyc != 9) begin failures++; $display("FAIL f8_idle_cycle got=%0d want=9", end_cyc); end
    checks++; if (err_n != 0 || viol_n != 0) begin failures++; $display("FAIL f8_err_viol got=%0d/%0d want=0/0", err_n, viol_n); end
    for (int j = 0; j < 8 && j < wr_n; j++) begin
      checks++; if (int'(wr_addr[j]) != exp_addr(j, 3) || wr_cyc[j] != j + 1) begin failures++;
        $display("FAIL f8_addr[%0d] got=%0d@%0d want=%0d@%0d", j, wr_addr[j], wr_cyc[j], exp_addr(j, 3), j + 1); end
      checks++; if (wr_data[j] !== word(base + j)) begin failures++;
        $display("FAIL f8_data[%0d] got=%h want=%h", j, wr_data[j], word(base + j)); end
    end
    $display("test_frame8 writes=%0d done_cyc=%0d", wr_n, done_cyc);
  endtask

  // 16-point frame with a 5-cycle FIFO-empty gap after the 3rd word.
  task automatic test_stall();
    int base;
    base = rd_ptr;
    run_frame(4'd4, 3, 5, 0, -1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL stall_timeout got=%b want=0", timed_out); end
    checks++; if (wr_n != 16 || rd_total != 16) begin failures++; $display("FAIL stall_counts got=%0d/%0d want=16/16", wr_n, rd_total); end
    checks++; if (done_n != 1 || done_cyc != 21) begin failures++; $display("FAIL stall_done got=%0d@%0d want=1@21", done_n, done_cyc); end
    checks++; if (viol_n != 0) begin failures++; $display("FAIL stall_rd_while_empty got=%0d want=0", viol_n); end
    checks++; if (wr_cyc[2] != 3 || wr_cyc[3] != 9) begin failures++;
      $display("FAIL stall_gap got=%0d,%0d want=3,9", wr_cyc[2], wr_cyc[3]); end
    for (int j = 0; j < 16 && j < wr_n; j++) begin
      checks++; if (int'(wr_addr[j]) != exp_addr(j, 4) || wr_data[j] !== word(base + j)) begin failures++;
        $display("FAIL stall_wr[%0d] got=%0d/%h want=%0d/%h", j, wr_addr[j], wr_data[j], exp_addr(j, 4), word(base + j)); end
    end
    $display("test_stall writes=%0d done_cyc=%0d", wr_n, done_cyc);
  endtask

  // Out-of-range frame lengths are rejected with a single error pulse.
  task automatic test_cfg_err();
    logic [3:0] bad [0:2];
    bad[0] = 4'd2; bad[1] = 4'd11; bad[2] = 4'd0;
    for (int t = 0; t < 3; t++) begin
      i_start = 1'b1; i_log2n = bad[t]; i_fifo_empty = 1'b0;
      @(posedge clk); #1;
      i_start = 1'b0;
      #1;
      checks++; if (o_cfg_err !== 1'b1 || o_busy !== 1'b0 || o_fifo_rd_en !== 1'b0) begin failures++;
        $display("FAIL cfg_err_pulse log2n=%0d got=err%b busy%b rd%b want=err1 busy0 rd0", bad[t], o_cfg_err, o_busy, o_fifo_rd_en); end
      @(posedge clk); #2;
      checks++; if (o_cfg_err !== 1'b0 || o_busy !== 1'b0 || o_fifo_rd_en !== 1'b0) begin failures++;
        $display("FAIL cfg_err_after log2n=%0d got=err%b busy%b rd%b want=err0 busy0 rd0", bad[t], o_cfg_err, o_busy, o_fifo_rd_en); end
      $display("test_cfg_err log2n=%0d", bad[t]);
    end
  endtask

  // Reset after 5 writes of a 16-point frame, then a fresh frame.
  task automatic test_reset_mid();
    int base;
    base = rd_ptr;
    run_frame(4'd4, -1, 0, 5, -1);
    checks++; if (timed_out !== 1'b0 || wr_n != 5 || done_n != 0) begin failures++;
      $display("FAIL mid_before got=to%b wr%0d done%0d want=to0 wr5 done0", timed_out, wr_n, done_n); end
    checks++; if (wr_data[4] !== word(base + 4)) begin failures++;
      $display("FAIL mid_data4 got=%h want=%h", wr_data[4], word(base + 4)); end
    i_rst = 1'b1;
    @(posedge clk); #1;
    if (rd_pending) begin i_fifo_dout = word(rd_ptr); rd_ptr++; end
    #1;
    checks++; if ({o_busy, o_fifo_rd_en, o_ram_we, o_load_done, o_cfg_err} !== 5'b0) begin failures++;
      $display("FAIL mid_reset_flags got=%b want=00000", {o_busy, o_fifo_rd_en, o_ram_we, o_load_done, o_cfg_err}); end
    checks++; if (o_ram_addr !== '0 || o_ram_wdata !== 32'd0) begin failures++;
      $display("FAIL mid_reset_bus got=%0d/%h want=0/0", o_ram_addr, o_ram_wdata); end
    i_rst = 1'b0;
    base = rd_ptr;
    run_frame(4'd3, -1, 0, 0, -1);
    checks++; if (timed_out !== 1'b0 || wr_n != 8 || done_n != 1 || done_cyc != 8) begin failures++;
      $display("FAIL mid_restart got=wr%0d done%0d@%0d want=wr8 done1@8", wr_n, done_n, done_cyc); end
    checks++; if (wr_data[7] !== word(base + 7) || int'(wr_addr[7]) != exp_addr(7, 3)) begin failures++;
      $display("FAIL mid_restart_last got=%0d/%h want=%0d/%h", wr_addr[7], wr_data[7], exp_addr(7, 3), word(base + 7)); end
    $display("test_reset_mid restart writes=%0d", wr_n);
  endtask

  // Starts in LOAD and LAST are ignored; a start right after LAST is taken.
  task automatic test_back_to_back();
    run_frame(4'd4, -1, 0, 0, 2);
    checks++; if (timed_out !== 1'b0 || wr_n != 16 || done_cyc != 16 || end_cyc != 17) begin failures++;
      $display("FAIL b2b_start_in_load got=wr%0d done@%0d end@%0d want=wr16 done@16 end@17", wr_n, done_cyc, end_cyc); end
    run_frame(4'd3, -1, 0, 0, 8);
    checks++; if (timed_out !== 1'b0 || wr_n != 8 || done_n != 1 || end_cyc != 9) begin failures++;
      $display("FAIL b2b_start_in_last got=wr%0d done%0d end@%0d want=wr8 done1 end@9", wr_n, done_n, end_cyc); end
    run_frame(4'd3, -1, 0, 0, -1);
    checks++; if (timed_out !== 1'b0 || wr_n != 8 || done_cyc != 8 || rd_total != 8) begin failures++;
      $display("FAIL b2b_after_last got=wr%0d rd%0d done@%0d want=wr8 rd8 done@8", wr_n, rd_total, done_cyc); end
    $display("test_back_to_back last_frame writes=%0d", wr_n);
  endtask

  initial begin
    test_reset();
    test_frame8();
    test_stall();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
